// File: rtl/riscv_pkg.sv
// Shared constants for the MU status slave: register map, responses
// and the read/write channel state encodings.
package riscv_pkg;

  localparam logic [3:0] ADDR_STATUS   = 4'h0;
  localparam logic [3:0] ADDR_BUSY_CNT = 4'h4;
  localparam logic [3:0] ADDR_CTRL     = 4'h8;
  localparam logic [3:0] ADDR_ID       = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } r_state_e;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } w_state_e;

  function automatic logic is_aligned(
    input logic [3:0] addr
  );
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/riscv_mu_status_slave_if.sv
// AXI4-Lite style register bus between a master and the MU status
// slave; five channels, each with a valid/ready handshake.
interface riscv_mu_status_slave_if;

  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/riscv_mu_busy_monitor.sv
// Tracks the core busy flag: rising-edge counter on the registered
// flag plus a sticky bit, both cleared by a one-cycle clr pulse.
module riscv_mu_busy_monitor (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_busy,
  input  logic        clr,
  output logic [31:0] busy_cnt,
  output logic        sticky
);

  logic        busy_q;
  logic        busy_d;
  logic        busy_prev_q;
  logic        busy_prev_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        sticky_q;
  logic        sticky_d;
  logic        rise;

  assign rise = busy_q & ~busy_prev_q;

  // An edge landing on the clear cycle survives the clear.
  always_comb begin
    busy_d      = i_busy;
    busy_prev_d = busy_q;
    if (clr) begin
      cnt_d = {31'b0, rise};
    end else begin
      cnt_d = cnt_q + {31'b0, rise};
    end
    sticky_d = (sticky_q & ~clr) | i_busy | rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= 1'b0;
      busy_prev_q <= 1'b0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      busy_prev_q <= busy_prev_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
    end
  end

  assign busy_cnt = cnt_q;
  assign sticky   = sticky_q;

endmodule

// File: rtl/riscv_mu_status_slave.sv
// Register slave exposing the MU busy status, busy counter, control
// and ID registers over an AXI4-Lite style bus.
module riscv_mu_status_slave
  import riscv_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h5253_4D31
) (
  input  logic clk,
  input  logic reset,
  input  logic i_busy,
  output logic o_enable,
  riscv_mu_status_slave_if.slave bus
);

  w_state_e    w_state_q;
  w_state_e    w_state_d;
  logic        aw_full_q;
  logic        aw_full_d;
  logic [3:0]  aw_addr_q;
  logic [3:0]  aw_addr_d;
  logic        w_full_q;
  logic        w_full_d;
  logic [1:0]  w_bits_q;
  logic [1:0]  w_bits_d;
  logic        w_strb0_q;
  logic        w_strb0_d;
  logic [1:0]  bresp_q;
  logic [1:0]  bresp_d;
  logic        enable_q;
  logic        enable_d;

  r_state_e    r_state_q;
  r_state_e    r_state_d;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic [1:0]  rresp_q;
  logic [1:0]  rresp_d;

  logic        b_hs;
  logic        aw_rdy;
  logic        w_rdy;
  logic        aw_hs;
  logic        w_hs;
  logic        do_write;
  logic        wr_ok;
  logic        wr_ctrl;
  logic        ctrl_clr;
  logic        ar_rdy;
  logic        ar_hs;
  logic [31:0] rd_val;
  logic [1:0]  rd_resp;
  logic [31:0] busy_cnt;
  logic        sticky;
  logic        unused_ok;

  // Only CTRL byte 0 carries state, so only those write bits are kept.
  assign unused_ok = ^{bus.wdata[31:2], bus.wstrb[3:1]};

  riscv_mu_busy_monitor u_mon (
    .clk      (clk),
    .reset    (reset),
    .i_busy   (i_busy),
    .clr      (ctrl_clr),
    .busy_cnt (busy_cnt),
    .sticky   (sticky)
  );

  // A buffer freed by the B handshake can refill in the same cycle.
  assign b_hs   = (w_state_q == W_RESP) & bus.bready;
  assign aw_rdy = (~aw_full_q | b_hs) & ~reset;
  assign w_rdy  = (~w_full_q | b_hs) & ~reset;
  assign aw_hs  = bus.awvalid & aw_rdy;
  assign w_hs   = bus.wvalid & w_rdy;

  assign do_write = (w_state_q == W_COLLECT)
                  & aw_full_q & w_full_q;
  assign wr_ok    = is_aligned(aw_addr_q)
                  & (aw_addr_q == ADDR_CTRL);
  assign wr_ctrl  = do_write & wr_ok & w_strb0_q;
  assign ctrl_clr = wr_ctrl & w_bits_q[1];

  always_comb begin
    w_state_d = w_state_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_bits_d  = w_bits_q;
    w_strb0_d = w_strb0_q;
    bresp_d   = bresp_q;
    enable_d  = enable_q;

    if (b_hs) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = bus.awaddr;
    end
    if (w_hs) begin
      w_full_d  = 1'b1;
      w_bits_d  = bus.wdata[1:0];
      w_strb0_d = bus.wstrb[0];
    end

    unique case (w_state_q)
      W_COLLECT: begin
        if (do_write) begin
          w_state_d = W_RESP;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          w_state_d = W_COLLECT;
        end
      end
    endcase

    if (wr_ctrl) begin
      enable_d = w_bits_q[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_COLLECT;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_bits_q  <= '0;
      w_strb0_q <= 1'b0;
      bresp_q   <= RESP_OKAY;
      enable_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_bits_q  <= w_bits_d;
      w_strb0_q <= w_strb0_d;
      bresp_q   <= bresp_d;
      enable_q  <= enable_d;
    end
  end

  assign ar_rdy = (r_state_q == R_IDLE) & ~reset;
  assign ar_hs  = bus.arvalid & ar_rdy;

  // Unaligned and unmapped addresses fall through to SLVERR.
  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    unique case (1'b1)
      bus.araddr == ADDR_STATUS:
        rd_val = {30'b0, sticky, i_busy};
      bus.araddr == ADDR_BUSY_CNT:
        rd_val = busy_cnt;
      bus.araddr == ADDR_CTRL:
        rd_val = {31'b0, enable_q};
      bus.araddr == ADDR_ID:
        rd_val = ID_VALUE;
      default:
        rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_VALID;
          rdata_d   = rd_val;
          rresp_d   = rd_resp;
        end
      end
      R_VALID: begin
        if (bus.rready) begin
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bus.awready = aw_rdy;
  assign bus.wready  = w_rdy;
  assign bus.bvalid  = (w_state_q == W_RESP);
  assign bus.bresp   = bresp_q;
  assign bus.arready = ar_rdy;
  assign bus.rvalid  = (r_state_q == R_VALID);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign o_enable    = enable_q;

endmodule

// File: tb/tb_riscv_mu_status_slave.sv
// Directed bench for the MU status slave: a vector table of register
// accesses plus hand-timed sequences for the multi-cycle cases.
module tb_riscv_mu_status_slave;
  import riscv_pkg::*;

  localparam logic [31:0] ID = 32'h5253_4D31;

  logic clk = 1'b0;
  logic reset;
  logic i_busy;
  logic o_enable;

  riscv_mu_status_slave_if bus ();

  riscv_mu_status_slave #(.ID_VALUE(ID)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_busy   (i_busy),
    .o_enable (o_enable),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lead > 0: W goes first by lead cycles; lead < 0: AW goes first.
  task automatic write_issue(input logic [3:0] a,
                             input logic [31:0] d,
                             input logic [3:0] s,
                             input int lead);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_f;
    bit w_f;
    int cyc = 0;
    bus.awaddr = a;
    bus.wdata  = d;
    bus.wstrb  = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awvalid = !aw_done && cyc >= lead;
      bus.wvalid  = !w_done && cyc >= -lead;
      #1;
      aw_f = bus.awvalid && bus.awready;
      w_f  = bus.wvalid && bus.wready;
      tick();
      aw_done = aw_done | aw_f;
      w_done  = w_done | w_f;
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done))
      chk("aw_w_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_b(output logic [1:0] r);
    int n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.bvalid)
      chk("bvalid_timeout", 32'd0, 32'd1);
    r = bus.bresp;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          input int lead,
                          output logic [1:0] r);
    write_issue(a, d, s, lead);
    wait_b(r);
    chk("b_single", {31'b0, bus.bvalid}, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] a,
                         output logic [31:0] d,
                         output logic [1:0] r);
    bit f = 0;
    int n = 0;
    bus.araddr = a;
    while (!f && n < 20) begin
      bus.arvalid = 1'b1;
      #1;
      f = bus.arready;
      tick();
      n++;
    end
    bus.arvalid = 1'b0;
    chk("r_latency", {31'b0, bus.rvalid}, 32'd1);
    n = 0;
    while (!bus.rvalid && n < 20) begin
      tick();
      n++;
    end
    if (!f || !bus.rvalid)
      chk("read_timeout", 32'd0, 32'd1);
    d = bus.rdata;
    r = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          n;
    bit          f;

    vecs[0]  = '{1'b1, 4'h4, 32'h0000_FFFF, 4'hF, 0, 32'h0, RESP_SLVERR};
    vecs[1]  = '{1'b0, 4'h6, 32'h0, 4'h0, 0, 32'h0, RESP_SLVERR};
    vecs[2]  = '{1'b0, 4'h4, 32'h0, 4'h0, 0, 32'h0, RESP_OKAY};
    vecs[3]  = '{1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, RESP_SLVERR};
    vecs[4]  = '{1'b1, 4'hC, 32'h0, 4'hF, -2, 32'h0, RESP_SLVERR};
    vecs[5]  = '{1'b1, 4'h9, 32'h0, 4'hF, 1, 32'h0, RESP_SLVERR};
    vecs[6]  = '{1'b0, 4'h8, 32'h0, 4'h0, 0, 32'h1, RESP_OKAY};
    vecs[7]  = '{1'b1, 4'h8, 32'h0, 4'h0, 0, 32'h0, RESP_OKAY};
    vecs[8]  = '{1'b0, 4'h8, 32'h0, 4'h0, 0, 32'h1, RESP_OKAY};
    vecs[9]  = '{1'b1, 4'h8, 32'hFFFF_FF00, 4'hE, -1, 32'h0, RESP_OKAY};
    vecs[10] = '{1'b0, 4'h8, 32'h0, 4'h0, 0, 32'h1, RESP_OKAY};
    vecs[11] = '{1'b1, 4'h8, 32'h2, 4'h1, 0, 32'h0, RESP_OKAY};
    vecs[12] = '{1'b0, 4'h8, 32'h0, 4'h0, 0, 32'h0, RESP_OKAY};
    vecs[13] = '{1'b0, 4'h1, 32'h0, 4'h0, 0, 32'h0, RESP_SLVERR};
    vecs[14] = '{1'b0, 4'hC, 32'h0, 4'h0, 0, ID, RESP_OKAY};
    vecs[15] = '{1'b1, 4'h8, 32'h1, 4'h1, 2, 32'h0, RESP_OKAY};
    vecs[16] = '{1'b0, 4'h8, 32'h0, 4'h0, 0, 32'h1, RESP_OKAY};
    vecs[17] = '{1'b0, 4'h0, 32'h0, 4'h0, 0, 32'h0, RESP_OKAY};

    reset       = 1'b1;
    i_busy      = 1'b0;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;

    repeat (3) tick();
    chk("rst_awready", {31'b0, bus.awready}, 32'd0);
    chk("rst_wready", {31'b0, bus.wready}, 32'd0);
    chk("rst_arready", {31'b0, bus.arready}, 32'd0);
    chk("rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_bresp", {30'b0, bus.bresp}, 32'd0);
    chk("rst_rresp", {30'b0, bus.rresp}, 32'd0);
    chk("rst_enable", {31'b0, o_enable}, 32'd0);

    reset = 1'b0;
    #1;
    chk("post_rst_awready", {31'b0, bus.awready}, 32'd1);
    chk("post_rst_wready", {31'b0, bus.wready}, 32'd1);
    chk("post_rst_arready", {31'b0, bus.arready}, 32'd1);

    do_read(4'hC, d, r);
    chk("id_rdata", d, ID);
    chk("id_rresp", {30'b0, r}, {30'b0, RESP_OKAY});

    do_write(4'h8, 32'h1, 4'hF, 3, r);
    chk("wlead_bresp", {30'b0, r}, {30'b0, RESP_OKAY});
    chk("wlead_enable", {31'b0, o_enable}, 32'd1);

    for (int k = 0; k < 3; k++) begin
      i_busy = 1'b1;
      tick();
      tick();
      i_busy = 1'b0;
      tick();
      tick();
    end
    tick();
    do_read(4'h4, d, r);
    chk("cnt3", d, 32'd3);
    do_read(4'h0, d, r);
    chk("sticky_set", d, 32'd2);
    do_write(4'h8, 32'h3, 4'hF, 0, r);
    chk("clr_bresp", {30'b0, r}, {30'b0, RESP_OKAY});
    do_read(4'h4, d, r);
    chk("cnt_cleared", d, 32'd0);
    do_read(4'h0, d, r);
    chk("sticky_cleared", d, 32'd0);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].lead, r);
        chk($sformatf("vec%0d_bresp", i), {30'b0, r},
            {30'b0, vecs[i].exp_resp});
      end else begin
        do_read(vecs[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), {30'b0, r},
            {30'b0, vecs[i].exp_resp});
      end
    end

    // Clear write lands on the same edge as a busy rising edge.
    bus.awaddr  = 4'h8;
    bus.wdata   = 32'h3;
    bus.wstrb   = 4'h1;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    i_busy      = 1'b1;
    #1;
    chk("race_awready", {31'b0, bus.awready}, 32'd1);
    chk("race_wready", {31'b0, bus.wready}, 32'd1);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    i_busy      = 1'b0;
    tick();
    chk("race_bvalid", {31'b0, bus.bvalid}, 32'd1);
    chk("race_bresp", {30'b0, bus.bresp}, {30'b0, RESP_OKAY});
    tick();
    bus.bready = 1'b0;
    chk("race_bdone", {31'b0, bus.bvalid}, 32'd0);
    do_read(4'h4, d, r);
    chk("race_cnt", d, 32'd1);
    do_read(4'h0, d, r);
    chk("race_sticky", d, 32'd2);

    // Read of CTRL captured on the edge that writes CTRL.
    bus.awaddr  = 4'h8;
    bus.wdata   = 32'h0;
    bus.wstrb   = 4'h1;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.araddr  = 4'h8;
    bus.arvalid = 1'b1;
    #1;
    chk("rw_arready", {31'b0, bus.arready}, 32'd1);
    tick();
    bus.arvalid = 1'b0;
    chk("rw_rvalid", {31'b0, bus.rvalid}, 32'd1);
    chk("rw_rdata_old", bus.rdata, 32'd1);
    chk("rw_bvalid", {31'b0, bus.bvalid}, 32'd1);
    chk("rw_enable_new", {31'b0, o_enable}, 32'd0);
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    chk("rw_rdone", {31'b0, bus.rvalid}, 32'd0);
    chk("rw_bdone", {31'b0, bus.bvalid}, 32'd0);
    do_read(4'h8, d, r);
    chk("rw_ctrl_after", d, 32'd0);

    // R channel stalled by rready low.
    bus.araddr = 4'hC;
    f = 0;
    n = 0;
    while (!f && n < 20) begin
      bus.arvalid = 1'b1;
      #1;
      f = bus.arready;
      tick();
      n++;
    end
    bus.arvalid = 1'b0;
    if (!f)
      chk("stall_ar_timeout", 32'd0, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_rvalid", k),
          {31'b0, bus.rvalid}, 32'd1);
      chk($sformatf("stall%0d_rdata", k), bus.rdata, ID);
      chk($sformatf("stall%0d_arready", k),
          {31'b0, bus.arready}, 32'd0);
      tick();
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("stall_rdone", {31'b0, bus.rvalid}, 32'd0);

    // Reset while a write response is pending.
    write_issue(4'h8, 32'h1, 4'h1, 0);
    n = 0;
    while (!bus.bvalid && n < 20) begin
      tick();
      n++;
    end
    chk("prerst_bvalid", {31'b0, bus.bvalid}, 32'd1);
    chk("prerst_enable", {31'b0, o_enable}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_bvalid", {31'b0, bus.bvalid}, 32'd0);
    chk("midrst_enable", {31'b0, o_enable}, 32'd0);
    chk("midrst_awready", {31'b0, bus.awready}, 32'd0);
    chk("midrst_arready", {31'b0, bus.arready}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rerst_awready", {31'b0, bus.awready}, 32'd1);
    chk("rerst_wready", {31'b0, bus.wready}, 32'd1);
    chk("rerst_arready", {31'b0, bus.arready}, 32'd1);
    tick();
    chk("rerst_no_b", {31'b0, bus.bvalid}, 32'd0);
    do_read(4'h8, d, r);
    chk("rerst_ctrl", d, 32'd0);
    do_read(4'h4, d, r);
    chk("rerst_cnt", d, 32'd0);
    do_read(4'h0, d, r);
    chk("rerst_status", d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_mu_status_slave.md
RISCV_MU_STATUS_SLAVE -- requirements
Module: riscv_mu_status_slave

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h5253_4D31, the constant returned by the ID register.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_busy  input  1  live busy flag from the core status manager.
REQ-005 SHALL have port o_enable  output  1  enable to the status manager, driven from CTRL[0].
REQ-006 SHALL have port awaddr  input  4  write address (byte address).
REQ-007 SHALL have port awvalid/awready  input/output  1 each  AW handshake.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port wstrb  input  4  byte strobes.
REQ-010 SHALL have port wvalid/wready  input/output  1 each  W handshake.
REQ-011 SHALL have port bresp  output  2  write response (OKAY = 2'b00, SLVERR = 2'b10).
REQ-012 SHALL have port bvalid/bready  output/input  1 each  B handshake.
REQ-013 SHALL have port araddr  input  4  read address.
REQ-014 SHALL have port arvalid/arready  input/output  1 each  AR handshake.
REQ-015 SHALL have port rdata  output  32  read data.
REQ-016 SHALL have port rresp  output  2  read response.
REQ-017 SHALL have port rvalid/rready  output/input  1 each  R handshake.

Function
REQ-018 SHALL decode the register map as follows: 0x0 STATUS (RO; [0] live i_busy, [1] sticky busy); 0x4 BUSY_CNT (RO); 0x8 CTRL (RW; [0] enable, [1] clear, write-1 self-clearing, reads 0); 0xC ID (RO).
REQ-019 SHALL set sticky busy on any cycle with i_busy=1 and clear it only when CTRL[1] is written as 1.
REQ-020 SHALL increment BUSY_CNT by 1 on each 0->1 edge of the registered i_busy, wrapping 0xFFFF_FFFF->0.
REQ-021 SHALL, when a clear write and a busy rising edge occur in the same cycle, apply the clear and also count the edge (BUSY_CNT=1, sticky=1).
REQ-022 SHALL accept AW and W independently in any order; each is held in a one-entry buffer, and its ready deasserts while the buffer is full.
REQ-023 SHALL perform the write, and assert bvalid, one cycle after both buffers are full; buffers free on the bvalid&bready handshake.
REQ-024 SHALL hold bvalid/bresp stable until bready; back-to-back writes are allowed with no idle cycle when bready=1.
REQ-025 SHALL apply wstrb to CTRL bytes; writes with wstrb=0 complete OKAY with no effect.
REQ-026 SHALL return SLVERR and change no state for writes to 0x0, 0x4 or 0xC and for unaligned addresses (awaddr[1:0]!=0).
REQ-027 SHALL assert arready only when the R channel is idle, and present rvalid with rdata captured one cycle after the AR handshake.
REQ-028 SHALL hold rvalid/rdata/rresp stable until rready; unaligned read addresses return rdata=0 with SLVERR.
REQ-029 SHALL implement the read path as a two-state FSM R_IDLE->R_VALID (on AR handshake) ->R_IDLE (on rready), and the write path as W_COLLECT->W_RESP->W_COLLECT.
REQ-030 SHALL make reads and writes independent; a read of CTRL in the same cycle as a CTRL write returns the pre-write value.

Reset
REQ-031 SHALL drive all outputs to zero during reset (awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, o_enable=0), clear CTRL, BUSY_CNT, sticky busy and the buffers, and return both FSMs to idle.
REQ-032 SHALL discard in-flight transactions on reset mid-operation without generating a response, and assert awready/wready/arready in the first cycle after reset deasserts.

Structure
REQ-033 SHALL place the register offsets, the RESP_OKAY/RESP_SLVERR constants and the read/write FSM state enums in riscv_pkg.
REQ-034 SHALL be a single module; the busy edge detector, counter and sticky bit may be a sub-module riscv_mu_busy_monitor.

Verification
REQ-035 SHALL cover: reset, then read 0xC -> rdata=0x5253_4D31, rresp=OKAY.
REQ-036 SHALL cover: W issued 3 cycles before AW, writing 0x8 with data 0x1 -> one bvalid with OKAY, o_enable=1 in the cycle after bvalid.
REQ-037 SHALL cover: i_busy pulsed 3 times, then read 0x4 -> 3; write 0x8 with data 0x3 -> subsequent reads of 0x4 and of 0x0[1] return 0.
REQ-038 SHALL cover: write 0x4 and read 0x6 -> both return SLVERR; BUSY_CNT unchanged.
REQ-039 SHALL cover: rready held low 5 cycles -> rvalid and rdata stable throughout, arready=0 throughout.
REQ-040 SHALL cover: reset asserted while bvalid=1 -> bvalid=0 immediately and o_enable=0.
